// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the program/data RAM port arbiter: FSM encodings, owner codes
// and the saturating write-counter helper.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_CPU_OWN    = 3'd0,
        ARB_DRAIN_CPU  = 3'd1,
        ARB_SWITCH     = 3'd2,
        ARB_PROG_OWN   = 3'd3,
        ARB_DRAIN_PROG = 3'd4
    } arb_state_t;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_PROG = 1'b1;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_mode_filter.sv
// Mode switch conditioner: 2-flop synchronizer followed by a stability filter that only
// moves mode_f after the synced level has disagreed with it for MODE_FILT cycles in a row.
module mode_filter #(
    parameter int MODE_FILT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic mode_sel,
    output logic mode_f
);

    localparam int CW = $clog2(MODE_FILT + 1);

    logic [1:0]    sync_reg;
    logic [CW-1:0] cnt_reg;
    logic          mode_f_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg   <= 2'b00;
            cnt_reg    <= '0;
            mode_f_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[0], mode_sel};
            // Any cycle of agreement restarts the stability count.
            if (sync_reg[1] != mode_f_reg) begin
                if (cnt_reg == CW'(MODE_FILT - 1)) begin
                    mode_f_reg <= sync_reg[1];
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign mode_f = mode_f_reg;

endmodule

// File: rtl/mem_port_arbiter.sv
// Owns the single-port program/data RAM: hands it to either the CPU bus port or the
// programmer port, with drain and a dead turnaround cycle between owners.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int MODE_FILT = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          mode_sel,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_adrs,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_run_en,
    input  logic          prog_req,
    input  logic          prog_wr,
    input  logic [AW-1:0] prog_adrs,
    input  logic [DW-1:0] prog_wdata,
    output logic          prog_gnt,
    output logic          prog_rvalid,
    output logic [DW-1:0] prog_rdata,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_data,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_q,
    output logic          owner,
    output logic [7:0]    wr_count,
    output logic [7:0]    wr_sum
);

    logic          mode_f;
    arb_state_t    state_reg;
    logic          owner_reg;
    logic          run_en_reg;
    logic          own_cpu;
    logic          own_prog;
    logic          cpu_rvalid_reg;
    logic          prog_rvalid_reg;
    logic [DW-1:0] cpu_rdata_reg;
    logic [DW-1:0] prog_rdata_reg;
    logic [AW-1:0] adrs_hold_reg;
    logic [DW-1:0] data_hold_reg;
    logic [7:0]    wr_count_reg;
    logic [7:0]    wr_sum_reg;

    mode_filter #(
        .MODE_FILT (MODE_FILT)
    ) u_mode_filter (
        .clock    (clock),
        .reset    (reset),
        .mode_sel (mode_sel),
        .mode_f   (mode_f)
    );

    // Grants are combinational so a request is issued in the cycle it is raised;
    // reset kills any access in flight.
    assign own_cpu  = (state_reg == ARB_CPU_OWN)  && !reset;
    assign own_prog = (state_reg == ARB_PROG_OWN) && !reset;
    assign cpu_gnt  = own_cpu  && cpu_req;
    assign prog_gnt = own_prog && prog_req;

    always_comb begin
        mem_adrs  = adrs_hold_reg;
        mem_data  = data_hold_reg;
        mem_wr_en = 1'b0;
        if (reset) begin
            mem_adrs = '0;
            mem_data = '0;
        end else if (own_cpu) begin
            mem_adrs  = cpu_adrs;
            mem_data  = cpu_wdata;
            mem_wr_en = cpu_gnt && cpu_wr;
        end else if (own_prog) begin
            mem_adrs  = prog_adrs;
            mem_data  = prog_wdata;
            mem_wr_en = prog_gnt && prog_wr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            adrs_hold_reg <= '0;
            data_hold_reg <= '0;
        end else if (own_cpu || own_prog) begin
            adrs_hold_reg <= mem_adrs;
            data_hold_reg <= mem_data;
        end
    end

    // Read return: RAM output is valid the cycle after the grant; pass it through in
    // that cycle and keep a copy so rdata stays stable afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            cpu_rvalid_reg  <= 1'b0;
            prog_rvalid_reg <= 1'b0;
            cpu_rdata_reg   <= '0;
            prog_rdata_reg  <= '0;
        end else begin
            cpu_rvalid_reg  <= cpu_gnt && !cpu_wr;
            prog_rvalid_reg <= prog_gnt && !prog_wr;
            if (cpu_rvalid_reg)
                cpu_rdata_reg <= mem_q;
            if (prog_rvalid_reg)
                prog_rdata_reg <= mem_q;
        end
    end

    assign cpu_rvalid  = cpu_rvalid_reg;
    assign prog_rvalid = prog_rvalid_reg;
    assign cpu_rdata   = cpu_rvalid_reg  ? mem_q : cpu_rdata_reg;
    assign prog_rdata  = prog_rvalid_reg ? mem_q : prog_rdata_reg;

    // Ownership FSM. owner flips as soon as the drain starts so the display shows the
    // destination; SWITCH re-evaluates mode_f, so a bounce returns to the original owner.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ARB_CPU_OWN;
            owner_reg  <= OWNER_CPU;
            run_en_reg <= 1'b1;
        end else begin
            unique case (state_reg)
                ARB_CPU_OWN: begin
                    if (mode_f) begin
                        state_reg  <= ARB_DRAIN_CPU;
                        owner_reg  <= OWNER_PROG;
                        run_en_reg <= 1'b0;
                    end
                end
                ARB_DRAIN_CPU: begin
                    if (!cpu_rvalid_reg)
                        state_reg <= ARB_SWITCH;
                end
                ARB_SWITCH: begin
                    if (mode_f) begin
                        state_reg  <= ARB_PROG_OWN;
                        owner_reg  <= OWNER_PROG;
                        run_en_reg <= 1'b0;
                    end else begin
                        state_reg  <= ARB_CPU_OWN;
                        owner_reg  <= OWNER_CPU;
                        run_en_reg <= 1'b1;
                    end
                end
                ARB_PROG_OWN: begin
                    if (!mode_f) begin
                        state_reg <= ARB_DRAIN_PROG;
                        owner_reg <= OWNER_CPU;
                    end
                end
                ARB_DRAIN_PROG: begin
                    if (!prog_rvalid_reg)
                        state_reg <= ARB_SWITCH;
                end
                default: begin
                    state_reg  <= ARB_CPU_OWN;
                    owner_reg  <= OWNER_CPU;
                    run_en_reg <= 1'b1;
                end
            endcase
        end
    end

    assign owner      = owner_reg;
    assign cpu_run_en = run_en_reg;

    // Programmer write statistics restart with every new programming session.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count_reg <= 8'h00;
            wr_sum_reg   <= 8'h00;
        end else if (state_reg == ARB_SWITCH && mode_f) begin
            wr_count_reg <= 8'h00;
            wr_sum_reg   <= 8'h00;
        end else if (prog_gnt && prog_wr) begin
            wr_count_reg <= sat_inc8(wr_count_reg);
            wr_sum_reg   <= wr_sum_reg + 8'(prog_wdata);
        end
    end

    assign wr_count = wr_count_reg;
    assign wr_sum   = wr_sum_reg;

endmodule
